// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code-lock controller.
// Handles digit entry, code comparison, open/relock timing, code
// re-programming and, optionally, a lockout after repeated failed tries.
// Optional feature macro: CODE_LOCK_LOCKOUT_EN (try counter + LOCKOUT state).
// Ports:
//   clk, n_rst         scan-rate clock, async active-low reset
//   key_value/valid    debounced key code with one-cycle strobe
//   code_set           level request for programming mode (honoured in OPEN)
//   unlocked           lock open
//   set_mode           programming mode active
//   fail               one-cycle pulse per rejected enter
//   locked_out         lockout active (0 when the feature is compiled out)
//   digit_cnt          number of buffered digits
//   entry_buf          buffered digits, newest in [3:0]
module code_lock_ctrl #(
  parameter int unsigned                CODE_DIGITS    = 6,
  parameter logic [CODE_DIGITS*4-1:0]   DEFAULT_CODE   = 24'h123456,
  parameter int unsigned                OPEN_CYCLES    = 50000,
  parameter int unsigned                MAX_TRIES      = 3,
  parameter int unsigned                LOCKOUT_CYCLES = 250000
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [3:0]                         key_value,
  input  logic                               key_valid,
  input  logic                               code_set,
  output logic                               unlocked,
  output logic                               set_mode,
  output logic                               fail,
  output logic                               locked_out,
  output logic [$clog2(CODE_DIGITS+1)-1:0]   digit_cnt,
  output logic [CODE_DIGITS*4-1:0]           entry_buf
);

  localparam int unsigned BW = CODE_DIGITS * 4;
  localparam int unsigned CW = $clog2(CODE_DIGITS + 1);
  localparam int unsigned OW = $clog2(OPEN_CYCLES + 1);

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_SET     = 2'd2;
`ifdef CODE_LOCK_LOCKOUT_EN
  localparam logic [1:0] ST_LOCKOUT = 2'd3;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
`endif

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] entry_buf_q, entry_buf_d;
  logic [CW-1:0] digit_cnt_q, digit_cnt_d;
  logic [BW-1:0] stored_q, stored_d;
  logic [OW-1:0] open_tmr_q, open_tmr_d;
  logic          fail_q, fail_d;
  logic          unlocked_q, unlocked_d;
  logic          set_mode_q, set_mode_d;
`ifdef CODE_LOCK_LOCKOUT_EN
  logic [TW-1:0] tries_q, tries_d;
  logic [LW-1:0] lock_tmr_q, lock_tmr_d;
  logic          locked_out_q, locked_out_d;
`endif

  // Key decode; D-F decode to nothing.
  logic is_digit_c, is_enter_c, is_clear_c, is_cancel_c, entry_full_c, clear_buf_c;
  assign is_digit_c   = key_valid && (key_value <= 4'd9);
  assign is_enter_c   = key_valid && (key_value == 4'hA);
  assign is_clear_c   = key_valid && (key_value == 4'hB);
  assign is_cancel_c  = key_valid && (key_value == 4'hC);
  assign entry_full_c = (digit_cnt_q == CW'(CODE_DIGITS));

  // Next-state, buffer and timer logic.
  always_comb begin
    state_d     = state_q;
    entry_buf_d = entry_buf_q;
    digit_cnt_d = digit_cnt_q;
    stored_d    = stored_q;
    open_tmr_d  = open_tmr_q;
    fail_d      = 1'b0;
    clear_buf_c = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    tries_d     = tries_q;
    lock_tmr_d  = lock_tmr_q;
`endif

    // Digit entry is common to every state that accepts keys.
`ifdef CODE_LOCK_LOCKOUT_EN
    if (state_q != ST_LOCKOUT) begin
`else
    begin
`endif
      if (is_digit_c && (digit_cnt_q < CW'(CODE_DIGITS))) begin
        entry_buf_d = (entry_buf_q << 4) | BW'(key_value);
        digit_cnt_d = digit_cnt_q + CW'(1);
      end else if (is_clear_c) begin
        clear_buf_c = 1'b1;
      end
    end

    case (state_q)
      ST_LOCKED: begin
        if (is_enter_c) begin
          clear_buf_c = 1'b1;
          if (entry_full_c && (entry_buf_q == stored_q)) begin
            state_d    = ST_OPEN;
            open_tmr_d = OW'(OPEN_CYCLES - 1);
`ifdef CODE_LOCK_LOCKOUT_EN
            tries_d    = '0;
`endif
          end else begin
            fail_d = 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
            tries_d = tries_q + TW'(1);
            if (tries_q == TW'(MAX_TRIES - 1)) begin
              state_d    = ST_LOCKOUT;
              lock_tmr_d = LW'(LOCKOUT_CYCLES - 1);
            end
`endif
          end
        end else if (is_cancel_c) begin
          clear_buf_c = 1'b1;
        end
      end
      ST_OPEN: begin
        // Expiry and cancel share one exit; cancel outranks code_set.
        if ((open_tmr_q == '0) || is_cancel_c) begin
          state_d     = ST_LOCKED;
          clear_buf_c = 1'b1;
        end else if (code_set) begin
          state_d     = ST_SET;
          clear_buf_c = 1'b1;
        end else begin
          open_tmr_d = open_tmr_q - OW'(1);
        end
      end
      ST_SET: begin
        if (is_enter_c) begin
          clear_buf_c = 1'b1;
          if (entry_full_c) begin
            stored_d   = entry_buf_q;
            state_d    = ST_OPEN;
            open_tmr_d = OW'(OPEN_CYCLES - 1);
          end else begin
            fail_d = 1'b1;
          end
        end else if (is_cancel_c) begin
          state_d     = ST_LOCKED;
          clear_buf_c = 1'b1;
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        clear_buf_c = 1'b1;
        if (lock_tmr_q == '0) begin
          state_d = ST_LOCKED;
          tries_d = '0;
        end else begin
          lock_tmr_d = lock_tmr_q - LW'(1);
        end
      end
`endif
      default: begin
        state_d     = ST_LOCKED;
        clear_buf_c = 1'b1;
      end
    endcase

    if (clear_buf_c) begin
      entry_buf_d = '0;
      digit_cnt_d = '0;
    end

    unlocked_d = (state_d == ST_OPEN);
    set_mode_d = (state_d == ST_SET);
`ifdef CODE_LOCK_LOCKOUT_EN
    locked_out_d = (state_d == ST_LOCKOUT);
`endif
  end

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_LOCKED;
      entry_buf_q <= '0;
      digit_cnt_q <= '0;
      stored_q    <= DEFAULT_CODE;
      open_tmr_q  <= '0;
      fail_q      <= 1'b0;
      unlocked_q  <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_buf_q <= entry_buf_d;
      digit_cnt_q <= digit_cnt_d;
      stored_q    <= stored_d;
      open_tmr_q  <= open_tmr_d;
      fail_q      <= fail_d;
      unlocked_q  <= unlocked_d;
      set_mode_q  <= set_mode_d;
    end
  end

`ifdef CODE_LOCK_LOCKOUT_EN
  // Retry counter and lockout timer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tries_q      <= '0;
      lock_tmr_q   <= '0;
      locked_out_q <= 1'b0;
    end else begin
      tries_q      <= tries_d;
      lock_tmr_q   <= lock_tmr_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign locked_out = locked_out_q;
`else
  // Lockout compiled out: its parameters are intentionally unused.
  logic unused_cfg_c;
  assign unused_cfg_c = ^{32'(MAX_TRIES), 32'(LOCKOUT_CYCLES)};
  assign locked_out   = 1'b0;
`endif

  assign unlocked  = unlocked_q;
  assign set_mode  = set_mode_q;
  assign fail      = fail_q;
  assign digit_cnt = digit_cnt_q;
  assign entry_buf = entry_buf_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed bench for code_lock_ctrl with a cycle-level
// reference model (digit queue + elapsed-cycle counters) checked every cycle,
// plus literal expectations at key points.
module tb_code_lock_ctrl;

  localparam int OPEN_N = 20;
  localparam int LOCK_N = 40;
  localparam int TRIES  = 3;

  logic        clk;
  logic        n_rst;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        code_set;
  logic        unlocked, set_mode, fail, locked_out;
  logic [2:0]  digit_cnt;
  logic [23:0] entry_buf;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  code_lock_ctrl #(
    .CODE_DIGITS   (6),
    .DEFAULT_CODE  (24'h123456),
    .OPEN_CYCLES   (OPEN_N),
    .MAX_TRIES     (TRIES),
    .LOCKOUT_CYCLES(LOCK_N)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_value (key_value),
    .key_valid (key_valid),
    .code_set  (code_set),
    .unlocked  (unlocked),
    .set_mode  (set_mode),
    .fail      (fail),
    .locked_out(locked_out),
    .digit_cnt (digit_cnt),
    .entry_buf (entry_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_LOCKED  = 0;
  localparam int M_OPEN    = 1;
  localparam int M_SET     = 2;
  localparam int M_LOCKOUT = 3;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  int          m_mode;
  int          m_digits[$];
  logic [23:0] m_stored;
  int          m_tries;
  int          m_elapsed;
  bit          m_fail;

  function automatic logic [23:0] pack_digits();
    logic [23:0] r = '0;
    foreach (m_digits[i]) r = (r << 4) | 24'(m_digits[i]);
    return r;
  endfunction

  task automatic model_step();
    int k;
    k = key_valid ? int'(key_value) : 15;
    m_fail = 1'b0;
    if (m_mode != M_LOCKOUT) begin
      if (k <= 9 && m_digits.size() < 6) m_digits.push_back(k);
      if (k == 11) m_digits.delete();
    end
    case (m_mode)
      M_LOCKED: begin
        if (k == 10) begin
          if (m_digits.size() == 6 && pack_digits() == m_stored) begin
            m_mode = M_OPEN; m_elapsed = 0; m_tries = 0;
          end else begin
            m_fail = 1'b1;
            m_tries++;
            if (LOCKOUT_EN && m_tries >= TRIES) begin
              m_mode = M_LOCKOUT; m_elapsed = 0;
            end
          end
          m_digits.delete();
        end
        if (k == 12) m_digits.delete();
      end
      M_OPEN: begin
        m_elapsed++;
        if (m_elapsed >= OPEN_N || k == 12) begin
          m_mode = M_LOCKED; m_digits.delete();
        end else if (code_set) begin
          m_mode = M_SET; m_digits.delete();
        end
      end
      M_SET: begin
        if (k == 10) begin
          if (m_digits.size() == 6) begin
            m_stored = pack_digits(); m_mode = M_OPEN; m_elapsed = 0;
          end else begin
            m_fail = 1'b1;
          end
          m_digits.delete();
        end else if (k == 12) begin
          m_mode = M_LOCKED; m_digits.delete();
        end
      end
      default: begin
        m_digits.delete();
        m_elapsed++;
        if (m_elapsed >= LOCK_N) begin
          m_mode = M_LOCKED; m_tries = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_mode = M_LOCKED; m_digits.delete(); m_stored = 24'h123456;
      m_tries = 0; m_elapsed = 0; m_fail = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_unlocked",   32'(unlocked),   32'(m_mode == M_OPEN));
      chk("m_set_mode",   32'(set_mode),   32'(m_mode == M_SET));
      chk("m_locked_out", 32'(locked_out), 32'(m_mode == M_LOCKOUT));
      chk("m_fail",       32'(fail),       32'(m_fail));
      chk("m_digit_cnt",  32'(digit_cnt),  32'(m_digits.size()));
      chk("m_entry_buf",  32'(entry_buf),  32'(pack_digits()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_value = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_value = 4'h0;
  endtask

  task automatic enter6(input logic [23:0] code);
    logic [23:0] c;
    c = code;
    for (int i = 0; i < 6; i++) begin
      press(c[23:20]);
      c = c << 4;
    end
  endtask

  initial begin
    n_rst = 1'b0; key_valid = 1'b0; key_value = 4'h0; code_set = 1'b0;
    idle(2);
    n_rst = 1'b1;
    check_en = 1'b1;
    chk("rst_unlocked", 32'(unlocked), 0);
    chk("rst_digit_cnt", 32'(digit_cnt), 0);
    chk("rst_entry_buf", 32'(entry_buf), 0);

    // 1: correct code opens for exactly OPEN_N cycles
    enter6(24'h123456);
    press(4'hA);
    chk("s1_open", 32'(unlocked), 1);
    chk("s1_cnt0", 32'(digit_cnt), 0);
    idle(OPEN_N - 1);
    chk("s1_last_open_cycle", 32'(unlocked), 1);
    idle(1);
    chk("s1_relocked", 32'(unlocked), 0);

    // 2: two failures, success clears tries
    enter6(24'h123457);
    press(4'hA);
    chk("s2_fail1", 32'(fail), 1);
    idle(1);
    chk("s2_fail_pulse_end", 32'(fail), 0);
    press(4'h1); press(4'h2); press(4'hA);
    chk("s2_fail2", 32'(fail), 1);
    chk("s2_closed", 32'(unlocked), 0);
    enter6(24'h123456);
    press(4'hA);
    chk("s2_open", 32'(unlocked), 1);
    press(4'hC);
    chk("s2_cancel", 32'(unlocked), 0);
    press(4'hA); press(4'hA);
    chk("s2_no_lockout", 32'(locked_out), 0);
    enter6(24'h123456);
    press(4'hA);
    press(4'hC);

    // 3: three failures
    press(4'hA); press(4'hA); press(4'hA);
    chk("s3_fail3", 32'(fail), 1);
`ifdef CODE_LOCK_LOCKOUT_EN
    chk("s3_locked_out", 32'(locked_out), 1);
    press(4'h1); press(4'h2);
    chk("s3_buf_zero", 32'(entry_buf), 0);
    idle(LOCK_N - 3);
    chk("s3_last_lockout_cycle", 32'(locked_out), 1);
    idle(1);
    chk("s3_lockout_end", 32'(locked_out), 0);
`else
    chk("s3_no_lockout", 32'(locked_out), 0);
`endif
    enter6(24'h123456);
    press(4'hA);
    chk("s3_open", 32'(unlocked), 1);

    // 4: reprogram to 987654 from OPEN
    code_set = 1'b1;
    idle(1);
    code_set = 1'b0;
    chk("s4_set_mode", 32'(set_mode), 1);
    enter6(24'h987654);
    press(4'hA);
    chk("s4_reopen", 32'(unlocked), 1);
    chk("s4_set_off", 32'(set_mode), 0);
    idle(OPEN_N - 1);
    chk("s4_timer_restart", 32'(unlocked), 1);
    idle(1);
    chk("s4_relock", 32'(unlocked), 0);
    enter6(24'h123456);
    press(4'hA);
    chk("s4_old_fails", 32'(fail), 1);
    enter6(24'h987654);
    press(4'hA);
    chk("s4_new_opens", 32'(unlocked), 1);
    idle(OPEN_N - 1);
    press(4'hC);
    chk("s4_c_at_expiry", 32'(unlocked), 0);
    idle(1);
    chk("s4_single_relock", 32'(unlocked), 0);
    enter6(24'h987654);
    press(4'hA);
    code_set = 1'b1;
    press(4'hC);
    code_set = 1'b0;
    chk("s4_c_beats_set", 32'(set_mode), 0);
    chk("s4_c_closes", 32'(unlocked), 0);

    // 5: overflow, clear, ignored key
    enter6(24'h123456);
    press(4'h7); press(4'h8);
    chk("s5_cnt_sat", 32'(digit_cnt), 6);
    chk("s5_buf_sat", 32'(entry_buf), 32'h123456);
    press(4'hB);
    chk("s5_clr_cnt", 32'(digit_cnt), 0);
    chk("s5_clr_buf", 32'(entry_buf), 0);
    press(4'h5);
    press(4'hE);
    chk("s5_e_ignored", 32'(entry_buf), 32'h5);
    chk("s5_e_cnt", 32'(digit_cnt), 1);
    press(4'hB);

    // 6: reset while in SET after reprogramming
    enter6(24'h987654);
    press(4'hA);
    code_set = 1'b1;
    idle(1);
    code_set = 1'b0;
    enter6(24'h111111);
    press(4'hA);
    chk("s6_reprog_open", 32'(unlocked), 1);
    code_set = 1'b1;
    idle(1);
    code_set = 1'b0;
    press(4'h2); press(4'h3);
    chk("s6_in_set", 32'(set_mode), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("s6_rst_set_mode", 32'(set_mode), 0);
    chk("s6_rst_buf", 32'(entry_buf), 0);
    chk("s6_rst_cnt", 32'(digit_cnt), 0);
    idle(2);
    #1 n_rst = 1'b1;
    idle(1);
    enter6(24'h123456);
    press(4'hA);
    chk("s6_default_opens", 32'(unlocked), 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
